stack_arbiter: RTL and testbench

//  Shares one stack instance between two requesters, A and B, with round-robin arbitration.

---
 rtl/stack_arbiter.sv | 107 ++++++++++
 tb/tb_stack_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter sharing one stack between requesters A and B
// Ports:
//   Clk, RstN                    clock, async active-low reset
//   Req_x, Op_x, Wdata_x         request, op (0 push / 1 pop), push data per requester
//   Gnt_x, Err_x, Rvalid_x       grant, reject and pop-return pulses per requester
//   Rdata                        last popped value, shared by both requesters
//   Busy                         high outside IDLE
//   St_Push, St_Pop, St_Data_In  stack strobes and write data
//   St_Data_Out, St_Full, St_Empty  stack read data and flags
module stack_arbiter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         Req_A,
  input  logic         Req_B,
  input  logic         Op_A,
  input  logic         Op_B,
  input  logic [W-1:0] Wdata_A,
  input  logic [W-1:0] Wdata_B,
  output logic         Gnt_A,
  output logic         Gnt_B,
  output logic         Err_A,
  output logic         Err_B,
  output logic         Rvalid_A,
  output logic         Rvalid_B,
  output logic [W-1:0] Rdata,
  output logic         Busy,
  output logic         St_Push,
  output logic         St_Pop,
  output logic [W-1:0] St_Data_In,
  input  logic [W-1:0] St_Data_Out,
  input  logic         St_Full,
  input  logic         St_Empty
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] CAPT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  logic [1:0] state;
  logic       ptr;
  logic       win_r;
  logic       op_r;
  logic       win;
  logic       op;
  logic       bad;
  // win: 0 = A, 1 = B; the pointer only decides when both are requesting
  always_comb begin
    win = (Req_A && Req_B) ? ptr : Req_B;
    op  = win ? Op_B : Op_A;
    bad = op ? St_Empty : St_Full;
  end
  assign Busy = state != IDLE;
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      win_r      <= 1'b0;
      op_r       <= 1'b0;
      Gnt_A      <= 1'b0;
      Gnt_B      <= 1'b0;
      Err_A      <= 1'b0;
      Err_B      <= 1'b0;
      Rvalid_A   <= 1'b0;
      Rvalid_B   <= 1'b0;
      Rdata      <= '0;
      St_Push    <= 1'b0;
      St_Pop     <= 1'b0;
      St_Data_In <= '0;
    end else begin
      Gnt_A    <= 1'b0;
      Gnt_B    <= 1'b0;
      Err_A    <= 1'b0;
      Err_B    <= 1'b0;
      Rvalid_A <= 1'b0;
      Rvalid_B <= 1'b0;
      St_Push  <= 1'b0;
      St_Pop   <= 1'b0;
      case (state)
        IDLE: if (Req_A || Req_B) begin
          // pointer always moves to the side that did not win this grant
          ptr   <= ~win;
          win_r <= win;
          op_r  <= op;
          Gnt_A <= ~win;
          Gnt_B <= win;
          Err_A <= ~win & bad;
          Err_B <= win & bad;
          if (!bad) begin
            state   <= ISSUE;
            St_Push <= ~op;
            St_Pop  <= op;
            if (!op) St_Data_In <= win ? Wdata_B : Wdata_A;
          end
        end
        ISSUE: state <= op_r ? CAPT : IDLE;
        CAPT: begin
          Rdata    <= St_Data_Out;
          Rvalid_A <= ~win_r;
          Rvalid_B <= win_r;
          state    <= RESP;
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: randomized self-checking bench for stack_arbiter against a transaction-level model
module tb_stack_arbiter;
  localparam int W = 4;
  localparam int DEPTH = 4;
  logic         Clk = 1'b0;
  logic         RstN = 1'b0;
  logic         Req_A = 1'b0, Req_B = 1'b0, Op_A = 1'b0, Op_B = 1'b0;
  logic [W-1:0] Wdata_A = '0, Wdata_B = '0;
  logic         Gnt_A, Gnt_B, Err_A, Err_B, Rvalid_A, Rvalid_B, Busy, St_Push, St_Pop;
  logic [W-1:0] Rdata, St_Data_In;
  logic [W-1:0] St_Data_Out = '0;
  logic         St_Full, St_Empty;
  logic [W-1:0] mem [DEPTH];
  int           sp = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  bit           ptr_m = 1'b0;
  logic [W-1:0] q [$];
  logic [W-1:0] e;
  always #5 Clk = ~Clk;
  stack_arbiter #(.W(W)) dut (
    .Clk(Clk), .RstN(RstN), .Req_A(Req_A), .Req_B(Req_B), .Op_A(Op_A), .Op_B(Op_B),
    .Wdata_A(Wdata_A), .Wdata_B(Wdata_B), .Gnt_A(Gnt_A), .Gnt_B(Gnt_B), .Err_A(Err_A),
    .Err_B(Err_B), .Rvalid_A(Rvalid_A), .Rvalid_B(Rvalid_B), .Rdata(Rdata), .Busy(Busy),
    .St_Push(St_Push), .St_Pop(St_Pop), .St_Data_In(St_Data_In), .St_Data_Out(St_Data_Out),
    .St_Full(St_Full), .St_Empty(St_Empty)
  );
  // stack device: registered top-of-stack output, valid the cycle after a pop
  assign St_Full  = sp == DEPTH;
  assign St_Empty = sp == 0;
  always @(posedge Clk) begin
    if (St_Push && sp < DEPTH) begin
      mem[sp] <= St_Data_In;
      sp      <= sp + 1;
    end else if (St_Pop && sp > 0) begin
      St_Data_Out <= mem[sp-1];
      sp          <= sp - 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge Clk);
    #1;
  endtask
  task automatic check_all_zero(input string tag);
    check(tag, {Gnt_A, Gnt_B, Err_A, Err_B, Rvalid_A, Rvalid_B, Busy, St_Push, St_Pop, Rdata, St_Data_In}, 0);
  endtask
  // one round: raise the chosen requests, serve each until granted, ending back in IDLE
  task automatic run_round(input bit ra, input bit rb, input bit oa, input bit ob,
                           input logic [W-1:0] da, input logic [W-1:0] db);
    bit w, op, bad;
    logic [W-1:0] d, x;
    Req_A = ra; Op_A = oa; Wdata_A = da;
    Req_B = rb; Op_B = ob; Wdata_B = db;
    for (int k = 0; k < 2 && (Req_A || Req_B); k++) begin
      w     = (Req_A && Req_B) ? ptr_m : Req_B;
      ptr_m = !w;
      op    = w ? Op_B : Op_A;
      d     = w ? Wdata_B : Wdata_A;
      bad   = op ? (q.size() == 0) : (q.size() == DEPTH);
      step;
      check("gnt_a", Gnt_A, !w);
      check("gnt_b", Gnt_B, w);
      check("err", {Err_A, Err_B}, bad ? (w ? 2'b01 : 2'b10) : 2'b00);
      check("st_push", St_Push, !bad && !op);
      check("st_pop", St_Pop, !bad && op);
      if (w) Req_B = 1'b0; else Req_A = 1'b0;
      if (bad) check("rvalid_on_err", {Rvalid_A, Rvalid_B}, 0);
      else if (!op) begin
        check("st_data_in", St_Data_In, d);
        check("busy_issue", Busy, 1);
        q.push_back(d);
        step;
      end else begin
        x = q.pop_back();
        step;
        check("rvalid_capt", {Rvalid_A, Rvalid_B}, 0);
        step;
        check("rvalid", {Rvalid_A, Rvalid_B}, w ? 2'b01 : 2'b10);
        check("rdata", Rdata, x);
        step;
      end
    end
    step;
    check("idle_gnt", {Gnt_A, Gnt_B}, 0);
    check("idle_busy", Busy, 0);
  endtask
  initial begin
    bit w;
    int sel;
    // both pushes requested from reset
    Req_A = 1'b1; Req_B = 1'b1; Wdata_A = 4'd1; Wdata_B = 4'd2;
    step;
    check_all_zero("reset_outputs");
    step;
    RstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w     = ptr_m;
      ptr_m = !w;
      step;
      check("alt_gnt", {Gnt_A, Gnt_B}, w ? 2'b01 : 2'b10);
      check("alt_data", St_Data_In, w ? 4'd2 : 4'd1);
      q.push_back(w ? 4'd2 : 4'd1);
      if (i == 3) begin
        Req_A = 1'b0;
        Req_B = 1'b0;
      end
      step;
    end
    step;
    run_round(0, 1, 0, 0, 0, 7);
    for (int i = 0; i < 4; i++) run_round(1, 0, 1, 0, 0, 0);
    run_round(1, 0, 1, 0, 0, 0);
    run_round(1, 0, 0, 0, 5, 0);
    run_round(1, 0, 0, 0, 3, 0);
    run_round(1, 0, 0, 0, 9, 0);
    run_round(0, 1, 0, 1, 0, 0);
    run_round(0, 1, 0, 1, 0, 0);
    // pop by B abandoned by reset while in CAPT
    Req_B = 1'b1; Op_B = 1'b1;
    step;
    check("rst_pop_gnt", {Gnt_B, St_Pop}, 2'b11);
    Req_B = 1'b0;
    e = q.pop_back();
    step;
    RstN = 1'b0;
    #1;
    check_all_zero("rst_mid_pop");
    step;
    step;
    check("rst_no_rvalid", {Rvalid_A, Rvalid_B}, 0);
    RstN = 1'b1;
    ptr_m = 1'b0;
    step;
    run_round(1, 1, 0, 0, 4'hA, 4'hB);
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(2);
      run_round(sel != 1, sel != 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                W'($urandom_range(15)), W'($urandom_range(15)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
